// File: rtl/ifetch_pkg.sv
// Definitions shared by the fetch unit, its prefetch queue and the instruction memory.
package ifetch_pkg;

  localparam int unsigned INST_BYTES      = 4;
  localparam int unsigned WORD_ALIGN_MASK = INST_BYTES - 1;

  // Access size encoding understood by the instruction memory.
  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } size_e;

  localparam size_e SIZE_WORD = SizeWord;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular register FIFO of fetched entries; flush empties it in a single cycle.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned  DEPTH   = 4,
  parameter type          entry_t = fetch_entry_t,
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  entry_t           i_data,
  input  logic             i_pop,
  output logic [CNT_W-1:0] o_count,
  output entry_t           o_head
);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only entries below the count are ever observed.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ifetch_pq.sv
// Sequential instruction fetch with a prefetch queue, bounded outstanding requests and
// redirect handling that drops responses still in flight from the old stream.
module ifetch_pq
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned       CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned       OUT_W = $clog2(MAX_OUT) + 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(WORD_ALIGN_MASK);

  typedef struct packed {
    logic [INST_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [OUT_W-1:0]  r_outstanding;
  logic [OUT_W-1:0]  r_drop_cnt;

  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_target;
  logic              w_credit;
  logic              w_space;
  logic              w_req_fire;
  logic              w_resp;
  logic              w_push;
  logic              w_pop;
  entry_t            w_push_data;
  entry_t            w_head;

  assign w_target = redirect_pc & ALIGN;

  // Queue slots are reserved at issue time, so a response never finds the queue full.
  assign w_credit       = 32'(r_outstanding) < MAX_OUT;
  assign w_space        = (32'(w_count) + 32'(r_outstanding)) < DEPTH;
  assign imem_req_valid = rst & ~redirect_valid & w_credit & w_space;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp            = imem_resp_valid & (r_outstanding != '0);
  assign w_push            = w_resp & (r_drop_cnt == '0) & ~redirect_valid;
  assign w_push_data.instr = imem_resp_data;
  assign w_push_data.pc    = r_resp_pc;

  assign out_valid = rst & (w_count != '0);
  assign w_pop     = out_valid & out_ready & ~redirect_valid;
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

  fetch_queue #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_queue (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_flush(redirect_valid),
    .i_push (w_push),
    .i_data (w_push_data),
    .i_pop  (w_pop),
    .o_count(w_count),
    .o_head (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + OUT_W'(w_req_fire) - OUT_W'(w_resp);
      if (redirect_valid) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        // Everything still in flight belongs to the old stream; this cycle's response too.
        r_drop_cnt <= r_outstanding - OUT_W'(w_resp);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + STEP;
        if (w_push)     r_resp_pc  <= r_resp_pc + STEP;
        if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - OUT_W'(1);
      end
    end
  end

  a_resp_has_request: assert property (@(posedge clk) disable iff (!rst)
    imem_resp_valid |-> (r_outstanding != '0))
    else $error("ifetch_pq: response with no outstanding request");

endmodule

// File: doc/ifetch_pq.md
Name: ifetch_pq

Overview:
- Parametrised next-generation instruction fetch unit with a prefetch queue.
- Issues sequential word fetches to a variable-latency, in-order instruction memory through a valid/ready request channel.
- Buffers returned words with their PCs in a DEPTH-entry queue and hands them to decode through a valid/ready channel.
- A redirect (taken branch/jump from exe) flushes the queue and discards stale in-flight responses.

Parameters:
- ADDR_W, 32: PC and memory address width.
- INST_W, 32: instruction word width.
- DEPTH, 4: prefetch queue entries; power of 2, >=2.
- MAX_OUT, 2: maximum outstanding memory requests, 1..DEPTH.
- RESET_PC, 0: fetch PC after reset; word aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- redirect_valid  in  1  redirect fetch stream this cycle.
- redirect_pc  in  ADDR_W  new fetch target; bits [1:0] are ignored (forced to 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  word-aligned fetch address.
- imem_resp_valid  in  1  response word valid; responses arrive in request order, at least 1 cycle after acceptance.
- imem_resp_data  in  INST_W  returned instruction.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode consumes head.
- out_instr  out  INST_W  head instruction.
- out_pc  out  ADDR_W  PC of head instruction.

Behaviour:
- Reset (rst==0 at a clock edge):
  - fetch_pc and resp_pc become RESET_PC.
  - Queue pointers, count, outstanding and drop_cnt become 0.
  - imem_req_valid and out_valid are 0 while rst is low.
  - The memory is reset by the same rst and abandons pending responses.
  - Reset mid-operation discards everything with no partial state.
- Request issue:
  - imem_req_valid = rst & !redirect_valid & (outstanding < MAX_OUT) & (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On fire (valid & ready): fetch_pc += 4 and outstanding += 1.
  - Address wraps modulo 2^ADDR_W.
- Response handling:
  - On imem_resp_valid, outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the data is discarded.
  - Otherwise the entry {resp_data, resp_pc} is pushed and resp_pc += 4.
  - The space reservation guarantees a push never meets a full queue.
  - Request fire and response in the same cycle leave outstanding unchanged.
  - imem_resp_valid while outstanding==0 is a protocol violation: ignored, and flagged by a simulation assertion.
- Output:
  - out_valid = (count != 0).
  - out_instr and out_pc come from the head register, with no combinational path from imem_resp.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle: count unchanged; legal even when count==DEPTH-1 or when full with pop.
  - Pointers wrap modulo DEPTH.
- Redirect (highest priority, overrides push and pop):
  - Queue cleared (count=0, pointers=0).
  - fetch_pc and resp_pc become {redirect_pc[ADDR_W-1:2], 2'b00}.
  - drop_cnt becomes outstanding minus 1 if imem_resp_valid is high that cycle, else outstanding. The response arriving that cycle is discarded.
  - No request is issued in the redirect cycle; issue resumes the next cycle.
  - A redirect while drop_cnt>0 recomputes drop_cnt by the same rule.
  - out_valid is 0 the cycle after a redirect.
- Latency:
  - Request accepted at cycle t, response at t+k (k>=1).
  - Entry written at the end of cycle t+k; out_valid visible at t+k+1.
  - With k=1 and always-ready memory/decode: sustained throughput of 1 instruction/cycle after 2 cycles of fill, given MAX_OUT>=2.
- Widths:
  - count is log2(DEPTH)+1 bits.
  - outstanding and drop_cnt are log2(MAX_OUT)+1 bits.

Decomposition:
- Shared package ifetch_pkg:
  - INST_BYTES=4 and WORD_ALIGN_MASK.
  - SIZE_WORD encoding, shared with the memory.
  - A fetch-entry struct {instr, pc}.
- One sub-module, fetch_queue:
  - Circular DEPTH-entry register FIFO with push, pop, flush, count, and head data.
- ifetch_pq keeps the PC, outstanding and drop logic.

Test Plan:
- Reset with RESET_PC=0x100, memory k=1 always ready, decode always ready -> request addresses 0x100, 0x104, 0x108…; out_pc sequence 0x100, 0x104…; first out_valid 2 cycles after reset release; 1 instruction/cycle thereafter.
- Decode out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests fire; imem_req_valid then stays 0; no entry lost or overwritten; the release drains 0x100..0x10C in order.
- Memory k=3 with 2 outstanding, redirect_pc=0x2002 -> both stale responses dropped; next out_pc=0x2000 with the correct instruction; drop_cnt reaches 0.
- Redirect in the same cycle as a response and a pop -> that response is discarded, queue is empty the next cycle, and fetch restarts at the target.
- imem_req_ready toggling randomly, k in 1..4, random out_ready -> out_pc is strictly +4 sequential with data matching a reference memory; count never exceeds DEPTH.
- rst pulled low mid-stream with a full queue -> the next cycle has out_valid=0 and imem_req_valid=0; after release, fetch restarts at RESET_PC.
